// File: rtl/demux1to2_buf.sv
// Buffered 1-to-2 demultiplexer.
// One valid/ready input stream is steered word by word to one of two output
// streams. Each output owns a small FIFO, so a stalled consumer only blocks
// words addressed to it. Each output also counts the words it has delivered.

// Per-output FIFO with a delivered-word counter.
module demux1to2_buf_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CW    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             valid,
  output logic             full,
  output logic [CW-1:0]    cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   FULL_OCC = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE_OCC  = (AW+1)'(1);
  localparam logic [AW-1:0] ONE_PTR  = AW'(1);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      occ_r;
  logic [AW:0]      occ_nxt_s;
  logic             valid_r;
  logic             full_r;
  logic [CW-1:0]    cnt_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Qualify handshakes against local state and compute next occupancy.
  always_comb begin
    do_push_s = push & ~full_r;
    do_pop_s  = pop & valid_r;
    case ({do_push_s, do_pop_s})
      2'b10:   occ_nxt_s = occ_r + ONE_OCC;
      2'b01:   occ_nxt_s = occ_r - ONE_OCC;
      default: occ_nxt_s = occ_r;
    endcase
  end

  // Storage, pointers, occupancy, registered status flags and delivery count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      occ_r    <= '0;
      valid_r  <= 1'b0;
      full_r   <= 1'b0;
      cnt_r    <= '0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r        <= wr_ptr_r + ONE_PTR;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + ONE_PTR;
        cnt_r    <= cnt_r + ONE_CNT;
      end
      occ_r   <= occ_nxt_s;
      valid_r <= (occ_nxt_s != '0);
      full_r  <= (occ_nxt_s == FULL_OCC);
    end
  end

  // Head of queue is read straight out of storage; stale when empty.
  assign rdata = mem_r[rd_ptr_r];
  assign valid = valid_r;
  assign full  = full_r;
  assign cnt   = cnt_r;

endmodule

// Top level: steering logic around two FIFOs.
module demux1to2_buf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CW    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [CW-1:0]    cnt0,
  output logic [CW-1:0]    cnt1
);

  logic full0_s;
  logic full1_s;
  logic push0_s;
  logic push1_s;
  logic pop0_s;
  logic pop1_s;

  // Ready depends only on the selected FIFO's full flag, never on in_valid,
  // so a full FIFO refuses a push even while it is popping.
  always_comb begin
    if (in_sel) begin
      in_ready = ~full1_s;
    end else begin
      in_ready = ~full0_s;
    end
  end

  // Route the accepted word to exactly one FIFO; pops are per-output.
  always_comb begin
    push0_s = in_valid & in_ready & ~in_sel;
    push1_s = in_valid & in_ready & in_sel;
    pop0_s  = out0_valid & out0_ready;
    pop1_s  = out1_valid & out1_ready;
  end

  demux1to2_buf_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) u_fifo0 (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push0_s),
    .wdata (in_data),
    .pop   (pop0_s),
    .rdata (out0_data),
    .valid (out0_valid),
    .full  (full0_s),
    .cnt   (cnt0)
  );

  demux1to2_buf_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) u_fifo1 (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push1_s),
    .wdata (in_data),
    .pop   (pop1_s),
    .rdata (out1_data),
    .valid (out1_valid),
    .full  (full1_s),
    .cnt   (cnt1)
  );

endmodule

// File: tb/tb_demux1to2_buf.sv
// Self-checking bench for demux1to2_buf: directed stimulus with a scoreboard.
module tb_demux1to2_buf;

  localparam int WIDTH = 8;
  localparam int DEPTH = 2;
  localparam int CW    = 8;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out1_data;
  logic             out1_valid;
  logic             out1_ready;
  logic [CW-1:0]    cnt0;
  logic [CW-1:0]    cnt1;

  int n_cmp = 0;
  int n_bad = 0;

  // Scoreboard queues and the bench's own model of FIFO state.
  logic [WIDTH-1:0] q0[$];
  logic [WIDTH-1:0] q1[$];
  int               occ0 = 0;
  int               occ1 = 0;
  logic [CW-1:0]    mcnt0 = '0;
  logic [CW-1:0]    mcnt1 = '0;

  demux1to2_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus: check state left by the previous edge,
  // drive new inputs, predict the outcome of the coming edge.
  task automatic step(input logic v, input logic s, input logic [WIDTH-1:0] d,
                      input logic r0, input logic r1);
    logic exp_rdy;
    logic p0;
    logic p1;
    @(posedge clk);
    #2;
    chk("cnt0", 32'(cnt0), 32'(mcnt0));
    chk("cnt1", 32'(cnt1), 32'(mcnt1));
    chk("out0_valid", 32'(out0_valid), 32'(occ0 > 0));
    chk("out1_valid", 32'(out1_valid), 32'(occ1 > 0));
    in_valid   = v;
    in_sel     = s;
    in_data    = d;
    out0_ready = r0;
    out1_ready = r1;
    #1;
    exp_rdy = s ? (occ1 != DEPTH) : (occ0 != DEPTH);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    p0 = r0 && (occ0 > 0);
    p1 = r1 && (occ1 > 0);
    if (v && exp_rdy) begin
      if (s) begin
        q1.push_back(d);
        occ1++;
      end else begin
        q0.push_back(d);
        occ0++;
      end
    end
    if (p0) begin
      occ0--;
      mcnt0 = mcnt0 + 8'd1;
    end
    if (p1) begin
      occ1--;
      mcnt1 = mcnt1 + 8'd1;
    end
  endtask

  // Assert reset in the middle of a cycle, check outputs at once, release.
  task automatic do_reset();
    @(posedge clk);
    #3;
    in_valid   = 1'b0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    in_sel     = 1'b0;
    rst_n      = 1'b0;
    #1;
    chk("rst_out0_valid", 32'(out0_valid), 32'd0);
    chk("rst_out1_valid", 32'(out1_valid), 32'd0);
    chk("rst_out0_data", 32'(out0_data), 32'd0);
    chk("rst_out1_data", 32'(out1_data), 32'd0);
    chk("rst_cnt0", 32'(cnt0), 32'd0);
    chk("rst_cnt1", 32'(cnt1), 32'd0);
    chk("rst_in_ready_sel0", 32'(in_ready), 32'd1);
    in_sel = 1'b1;
    #1;
    chk("rst_in_ready_sel1", 32'(in_ready), 32'd1);
    in_sel = 1'b0;
    q0.delete();
    q1.delete();
    occ0  = 0;
    occ1  = 0;
    mcnt0 = '0;
    mcnt1 = '0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Monitor: whenever an output handshake is pending, the head of that
  // output's scoreboard queue must be what the DUT presents.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out0_valid && out0_ready) begin
        if (q0.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL out0_unexpected: got 0x%0h with empty scoreboard at %0t", out0_data, $time);
        end else begin
          chk("out0_data", 32'(out0_data), 32'(q0.pop_front()));
        end
      end
      if (out1_valid && out1_ready) begin
        if (q1.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL out1_unexpected: got 0x%0h with empty scoreboard at %0t", out1_data, $time);
        end else begin
          chk("out1_data", 32'(out1_data), 32'(q1.pop_front()));
        end
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 200000", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n      = 1'b0;
    in_data    = '0;
    in_sel     = 1'b0;
    in_valid   = 1'b0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    #3;
    chk("init_out0_valid", 32'(out0_valid), 32'd0);
    chk("init_out1_valid", 32'(out1_valid), 32'd0);
    chk("init_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Steering with both consumers ready.
    step(1'b1, 1'b0, 8'hA1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 8'hB2, 1'b1, 1'b1);
    step(1'b1, 1'b0, 8'hA3, 1'b1, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    chk("steer_cnt0", 32'(cnt0), 32'd2);
    chk("steer_cnt1", 32'(cnt1), 32'd1);

    // Reset mid-operation with one word held in each FIFO.
    step(1'b1, 1'b0, 8'hC0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'hC1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    do_reset();

    // Isolation: FIFO 0 full, FIFO 1 still accepts.
    step(1'b1, 1'b0, 8'h11, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h12, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h13, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h55, 1'b0, 1'b1);
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);

    // Full FIFO with pop: push refused this cycle, taken the next.
    step(1'b1, 1'b0, 8'h13, 1'b1, 1'b0);
    step(1'b1, 1'b0, 8'h13, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

    // Simultaneous push and pop on FIFO 1 for 20 cycles.
    step(1'b1, 1'b1, 8'h20, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 8'(8'h21 + i), 1'b0, 1'b1);
    end
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("stream_cnt1", 32'(cnt1), 32'd22);

    // Counter wrap: 257 deliveries on output 0 from a fresh reset.
    do_reset();
    for (int i = 0; i < 257; i++) begin
      step(1'b1, 1'b0, 8'(i), 1'b1, 1'b0);
    end
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("wrap_cnt0", 32'(cnt0), 32'd1);

    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
